bedrock_reg_endpoint: RTL and testbench

- Single-beat BedRock memory-command endpoint that maps incoming I/O commands onto a bank of els_p register-like devices.
- Decodes the command address against per-element match patterns and issues a one-cycle read or write strobe to the matched element.
- Registers the response header and data, and returns one response per command.
- Sits between an I/O network port and simple device logic (host ROMs, putchar, finish registers).

---
 rtl/bedrock_reg_endpoint.sv | 134 +++++++++++++
 tb/tb_bedrock_reg_endpoint.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bedrock_reg_endpoint.sv
// bedrock_reg_endpoint: single-beat BedRock I/O command endpoint.
// Each accepted command is decoded against per-element wildcard address
// patterns. A matched element gets a one-cycle read or write strobe. The
// command header is then echoed back as a registered response, one cycle
// after it is accepted.
//
// I/O header layout, LSB first:
//   [3:0]   msg_type
//   [7:4]   subop
//   [..]    addr    (paddr_width_p bits)
//   [..]    size    (3 bits, log2 of the byte count)
//   [..]    payload (payload_width_p bits)
module bedrock_reg_endpoint #(
    parameter int paddr_width_p    = 40,
    parameter int payload_width_p  = 16,
    parameter int data_width_p     = 64,
    parameter int els_p            = 1,
    parameter int reg_addr_width_p = 20,
    // Wildcard patterns; X/Z bits are don't-care in the decode.
    parameter logic [els_p-1:0][reg_addr_width_p-1:0] base_addr_p = '0,
    localparam int header_width_lp = 4 + 4 + paddr_width_p + 3 + payload_width_p,
    localparam int lg_bytes_lp     = ((data_width_p / 8) == 1) ? 1 : $clog2(data_width_p / 8),
    localparam int size_width_lp   = $clog2(lg_bytes_lp + 1)
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,

    input  logic [header_width_lp-1:0]           mem_cmd_header_i,
    input  logic [data_width_p-1:0]              mem_cmd_data_i,
    input  logic                                 mem_cmd_v_i,
    output logic                                 mem_cmd_ready_and_o,
    input  logic                                 mem_cmd_last_i,

    output logic [header_width_lp-1:0]           mem_resp_header_o,
    output logic [data_width_p-1:0]              mem_resp_data_o,
    output logic                                 mem_resp_v_o,
    input  logic                                 mem_resp_ready_and_i,
    output logic                                 mem_resp_last_o,

    output logic [els_p-1:0]                     r_v_o,
    output logic [els_p-1:0]                     w_v_o,
    output logic [reg_addr_width_p-1:0]          addr_o,
    output logic [size_width_lp-1:0]             size_o,
    output logic [data_width_p-1:0]              data_o,
    input  logic [els_p-1:0][data_width_p-1:0]   data_i
);

    // BedRock memory message types
    localparam logic [3:0] MSG_RD    = 4'b0000;
    localparam logic [3:0] MSG_WR    = 4'b0001;
    localparam logic [3:0] MSG_UC_RD = 4'b0010;
    localparam logic [3:0] MSG_UC_WR = 4'b0011;

    localparam int addr_lsb_lp = 8;
    localparam int size_lsb_lp = 8 + paddr_width_p;

    logic                       r_resp_v;
    logic [header_width_lp-1:0] r_resp_header;
    logic [data_width_p-1:0]    r_resp_data;

    logic [3:0]                 w_msg_type;
    logic                       w_is_read;
    logic                       w_is_write;
    logic                       w_cmd_fire;
    logic                       w_resp_fire;
    logic [els_p-1:0]           w_hit;
    logic [els_p-1:0]           w_sel;
    logic                       w_any_hit;
    logic [data_width_p-1:0]    w_rdata;
    logic                       w_unused;

    // Fields taken straight from the live command, whether or not it is valid
    assign w_msg_type = mem_cmd_header_i[3:0];
    assign addr_o     = mem_cmd_header_i[addr_lsb_lp +: reg_addr_width_p];
    assign size_o     = mem_cmd_header_i[size_lsb_lp +: size_width_lp];
    assign data_o     = mem_cmd_data_i;

    assign w_is_read  = (w_msg_type == MSG_RD) | (w_msg_type == MSG_UC_RD);
    assign w_is_write = (w_msg_type == MSG_WR) | (w_msg_type == MSG_UC_WR);

    // The reset term keeps the endpoint closed while reset is held
    assign mem_cmd_ready_and_o = reset_i & (~r_resp_v | mem_resp_ready_and_i);
    assign w_cmd_fire          = mem_cmd_v_i & mem_cmd_ready_and_o;
    assign w_resp_fire         = r_resp_v & mem_resp_ready_and_i;

    // Only single-beat commands exist, so the last flag and the remaining
    // header bits carry no control meaning here
    assign w_unused = &{1'b0, mem_cmd_last_i, mem_cmd_header_i};

    genvar g;
    generate
        for (g = 0; g < els_p; g++) begin : g_match
            assign w_hit[g] = (addr_o ==? base_addr_p[g]);
        end
    endgenerate

    // Priority select: the lowest matching index wins; its read data is muxed out
    always_comb begin
        w_sel     = '0;
        w_any_hit = 1'b0;
        w_rdata   = '0;
        for (int i = 0; i < els_p; i++) begin
            w_sel[i]  = w_hit[i] & ~w_any_hit;
            w_any_hit = w_any_hit | w_hit[i];
            w_rdata   = w_rdata | ({data_width_p{w_sel[i]}} & data_i[i]);
        end
    end

    assign r_v_o = w_sel & {els_p{w_cmd_fire & w_is_read}};
    assign w_v_o = w_sel & {els_p{w_cmd_fire & w_is_write}};

    // Response register: load on accept, clear on drain, otherwise hold
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_resp_v      <= 1'b0;
            r_resp_header <= '0;
            r_resp_data   <= '0;
        end else if (w_cmd_fire) begin
            r_resp_v      <= 1'b1;
            r_resp_header <= mem_cmd_header_i;
            r_resp_data   <= (w_is_read & w_any_hit) ? w_rdata : '0;
        end else if (w_resp_fire) begin
            r_resp_v      <= 1'b0;
        end else begin
            r_resp_v      <= r_resp_v;
        end
    end

    assign mem_resp_v_o      = r_resp_v;
    assign mem_resp_last_o   = r_resp_v;
    assign mem_resp_header_o = r_resp_header;
    assign mem_resp_data_o   = r_resp_data;

endmodule

// File: tb/tb_bedrock_reg_endpoint.sv
// Testbench for bedrock_reg_endpoint: directed scenarios followed by
// randomized traffic. All results are checked against a transaction-level
// model that keeps a queue of outstanding responses.
module tb_bedrock_reg_endpoint;

    localparam int PADDR = 40;
    localparam int PAYW  = 16;
    localparam int DW    = 64;
    localparam int ELS   = 5;
    localparam int RAW   = 8;
    localparam int HW    = 4 + 4 + PADDR + 3 + PAYW;
    localparam int SZW   = 2;

    // idx0=01, idx1=02, idx2=0000_??11, idx3=07, idx4=0000_1?00
    localparam logic [ELS-1:0][RAW-1:0] BASE =
        {8'b0000_1?00, 8'h07, 8'b0000_??11, 8'h02, 8'h01};

    logic                     clk_i = 1'b0;
    logic                     reset_i;
    logic [HW-1:0]            mem_cmd_header_i;
    logic [DW-1:0]            mem_cmd_data_i;
    logic                     mem_cmd_v_i;
    logic                     mem_cmd_ready_and_o;
    logic                     mem_cmd_last_i;
    logic [HW-1:0]            mem_resp_header_o;
    logic [DW-1:0]            mem_resp_data_o;
    logic                     mem_resp_v_o;
    logic                     mem_resp_ready_and_i;
    logic                     mem_resp_last_o;
    logic [ELS-1:0]           r_v_o;
    logic [ELS-1:0]           w_v_o;
    logic [RAW-1:0]           addr_o;
    logic [SZW-1:0]           size_o;
    logic [DW-1:0]            data_o;
    logic [ELS-1:0][DW-1:0]   data_i;

    bedrock_reg_endpoint #(
        .paddr_width_p    (PADDR),
        .payload_width_p  (PAYW),
        .data_width_p     (DW),
        .els_p            (ELS),
        .reg_addr_width_p (RAW),
        .base_addr_p      (BASE)
    ) dut (
        .clk_i                (clk_i),
        .reset_i              (reset_i),
        .mem_cmd_header_i     (mem_cmd_header_i),
        .mem_cmd_data_i       (mem_cmd_data_i),
        .mem_cmd_v_i          (mem_cmd_v_i),
        .mem_cmd_ready_and_o  (mem_cmd_ready_and_o),
        .mem_cmd_last_i       (mem_cmd_last_i),
        .mem_resp_header_o    (mem_resp_header_o),
        .mem_resp_data_o      (mem_resp_data_o),
        .mem_resp_v_o         (mem_resp_v_o),
        .mem_resp_ready_and_i (mem_resp_ready_and_i),
        .mem_resp_last_o      (mem_resp_last_o),
        .r_v_o                (r_v_o),
        .w_v_o                (w_v_o),
        .addr_o               (addr_o),
        .size_o               (size_o),
        .data_o               (data_o),
        .data_i               (data_i)
    );

    // 10 ns clock
    always #5 clk_i = ~clk_i;

    int checks_s = 0;
    int errors_s = 0;

    // Reference-model state: queue of expected responses
    logic [HW-1:0] exp_hdr_q[$];
    logic [DW-1:0] exp_data_q[$];

    // Pattern table written as value/care masks
    logic [7:0] pat_val [ELS] = '{8'h01, 8'h02, 8'h03, 8'h07, 8'h08};
    logic [7:0] pat_care[ELS] = '{8'hFF, 8'hFF, 8'hF3, 8'hFF, 8'hFB};

    // Single comparison point
    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks_s++;
        if (got !== exp) begin
            errors_s++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int match_idx(input logic [7:0] a);
        for (int i = 0; i < ELS; i++)
            if ((a & pat_care[i]) == (pat_val[i] & pat_care[i])) return i;
        return -1;
    endfunction

    function automatic logic [HW-1:0] mk_hdr(input logic [3:0] mt, input logic [7:0] a);
        logic [PADDR-1:0] pa;
        logic [2:0]       sz;
        logic [PAYW-1:0]  pl;
        logic [3:0]       sub;
        pa  = {$urandom(), a};
        sz  = 3'($urandom_range(0, 7));
        pl  = 16'($urandom());
        sub = 4'($urandom_range(0, 15));
        return {pl, sz, pa, sub, mt};
    endfunction

    // One clock cycle: drive, check against the model, clock, update the model
    task automatic run_cycle(input logic v, input logic [3:0] mt, input logic [7:0] a,
                             input logic [DW-1:0] d, input logic rr);
        logic [HW-1:0]  hdr;
        logic           exp_ready, fire, is_rd, is_wr, consumed;
        int             idx;
        logic [ELS-1:0] exp_r, exp_w;
        logic [DW-1:0]  exp_d;
        hdr                  = mk_hdr(mt, a);
        mem_cmd_header_i     = hdr;
        mem_cmd_data_i       = d;
        mem_cmd_v_i          = v;
        mem_resp_ready_and_i = rr;
        #1;
        exp_ready = (exp_hdr_q.size() == 0) || rr;
        check_val("cmd_ready", 128'(mem_cmd_ready_and_o), 128'(exp_ready));
        check_val("resp_v", 128'(mem_resp_v_o), 128'(exp_hdr_q.size() != 0));
        check_val("resp_last", 128'(mem_resp_last_o), 128'(exp_hdr_q.size() != 0));
        if (exp_hdr_q.size() != 0) begin
            check_val("resp_hdr", 128'(mem_resp_header_o), 128'(exp_hdr_q[0]));
            check_val("resp_data", 128'(mem_resp_data_o), 128'(exp_data_q[0]));
        end
        idx   = match_idx(a);
        fire  = v && exp_ready;
        is_rd = (mt == 4'd0) || (mt == 4'd2);
        is_wr = (mt == 4'd1) || (mt == 4'd3);
        exp_r = (fire && is_rd && idx >= 0) ? ELS'(1 << idx) : '0;
        exp_w = (fire && is_wr && idx >= 0) ? ELS'(1 << idx) : '0;
        exp_d = (is_rd && idx >= 0) ? data_i[idx] : '0;
        check_val("r_v", 128'(r_v_o), 128'(exp_r));
        check_val("w_v", 128'(w_v_o), 128'(exp_w));
        check_val("addr", 128'(addr_o), 128'(a));
        check_val("size", 128'(size_o), 128'(hdr[8+PADDR +: 2]));
        check_val("data_o", 128'(data_o), 128'(d));
        consumed = (exp_hdr_q.size() != 0) && rr;
        @(posedge clk_i);
        if (consumed) begin
            void'(exp_hdr_q.pop_front());
            void'(exp_data_q.pop_front());
        end
        if (fire) begin
            exp_hdr_q.push_back(hdr);
            exp_data_q.push_back(exp_d);
        end
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < ELS; i++) data_i[i] = {$urandom(), $urandom()};
    endtask

    logic [7:0] addr_pool[10] = '{8'h01, 8'h02, 8'h03, 8'h07, 8'h0B, 8'h0C, 8'h08, 8'h00, 8'h05, 8'hFF};

    initial begin
        reset_i              = 1'b0;
        mem_cmd_v_i          = 1'b1;
        mem_cmd_last_i       = 1'b1;
        mem_resp_ready_and_i = 1'b1;
        mem_cmd_header_i     = mk_hdr(4'd2, 8'h02);
        mem_cmd_data_i       = 64'h0;
        rand_data();

        // Reset state: a valid, matching command must not get through
        @(posedge clk_i); #1;
        check_val("rst_resp_v", 128'(mem_resp_v_o), 128'(0));
        check_val("rst_hdr", 128'(mem_resp_header_o), 128'(0));
        check_val("rst_data", 128'(mem_resp_data_o), 128'(0));
        check_val("rst_ready", 128'(mem_cmd_ready_and_o), 128'(0));
        check_val("rst_r_v", 128'(r_v_o), 128'(0));
        check_val("rst_w_v", 128'(w_v_o), 128'(0));
        reset_i = 1'b1;

        // Read hit on element 1
        data_i[1] = 64'hDEAD_BEEF;
        run_cycle(1'b1, 4'd2, 8'h02, 64'h0, 1'b1);
        // Write hit at 3 (pattern 0000_??11) carrying 0x41, drains the read
        run_cycle(1'b1, 4'd3, 8'h03, 64'h41, 1'b1);
        // Wildcard 1?00 matches both 0x0C and 0x08
        run_cycle(1'b1, 4'd0, 8'h0C, 64'h0, 1'b1);
        run_cycle(1'b1, 4'd1, 8'h08, 64'h5, 1'b1);
        // 0x07 hits element 2 and element 3; only element 2 strobes
        run_cycle(1'b1, 4'd0, 8'h07, 64'h0, 1'b1);
        run_cycle(1'b1, 4'd3, 8'h07, 64'h9, 1'b1);
        // Miss plus amo/pre loopback
        run_cycle(1'b1, 4'd0, 8'h55, 64'h0, 1'b1);
        run_cycle(1'b1, 4'd5, 8'h02, 64'h0, 1'b1);
        run_cycle(1'b1, 4'd4, 8'h01, 64'h0, 1'b1);
        run_cycle(1'b0, 4'd0, 8'h00, 64'h0, 1'b1);

        // Backpressure: one response pending, a second command waits 5 cycles
        run_cycle(1'b1, 4'd2, 8'h02, 64'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            rand_data();
            run_cycle(1'b1, 4'd0, 8'h01, 64'h0, 1'b0);
        end
        run_cycle(1'b1, 4'd0, 8'h01, 64'h0, 1'b1);
        run_cycle(1'b0, 4'd0, 8'h00, 64'h0, 1'b1);

        // Reset mid-operation drops the pending response without a clock edge
        run_cycle(1'b1, 4'd2, 8'h02, 64'h0, 1'b0);
        run_cycle(1'b0, 4'd0, 8'h00, 64'h0, 1'b0);
        check_val("pre_rst_v", 128'(mem_resp_v_o), 128'(1));
        mem_cmd_v_i      = 1'b1;
        mem_cmd_header_i = mk_hdr(4'd2, 8'h02);
        #1 reset_i = 1'b0;
        #1;
        check_val("midrst_resp_v", 128'(mem_resp_v_o), 128'(0));
        check_val("midrst_ready", 128'(mem_cmd_ready_and_o), 128'(0));
        check_val("midrst_r_v", 128'(r_v_o), 128'(0));
        exp_hdr_q.delete();
        exp_data_q.delete();
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        run_cycle(1'b1, 4'd0, 8'h03, 64'h0, 1'b1);
        run_cycle(1'b0, 4'd0, 8'h00, 64'h0, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [7:0] a;
            rand_data();
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : addr_pool[$urandom_range(0, 9)];
            run_cycle(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 5)), a,
                      {$urandom(), $urandom()}, 1'($urandom_range(0, 2) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks_s, errors_s);
        $finish;
    end

endmodule
